// File: rtl/serial_chain_pkg.sv
// ---------------------------------------------------------------------------
// serial_chain_pkg
//
// Shared definitions for the serial_chain_out block: the state encoding of
// the transfer controller and a helper that sizes the bit counter.
//
// Contents:
//   STATE_*_ENC  raw state encodings
//   state_e      controller state type (IDLE, SHIFT, LATCH)
//   cntWidth()   width of a counter that must reach total-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package serial_chain_pkg;

    // Raw encodings kept as localparams so they can be referenced in
    // documentation or debug tooling independently of the enum type.
    localparam logic [1:0] STATE_IDLE_ENC  = 2'd0;
    localparam logic [1:0] STATE_SHIFT_ENC = 2'd1;
    localparam logic [1:0] STATE_LATCH_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE_ENC,
        ST_SHIFT = STATE_SHIFT_ENC,
        ST_LATCH = STATE_LATCH_ENC
    } state_e;

    // The bit counter only needs to reach total-1 because the exit is taken
    // on that value, so clog2(total) bits suffice; a one-bit floor keeps the
    // counter legal for degenerate single-bit chains.
    function automatic int unsigned cntWidth(input int unsigned total);
        if (total <= 1) begin
            return 1;
        end
        return $clog2(total);
    endfunction

endpackage

// File: rtl/serial_chain_shifter.sv
// ---------------------------------------------------------------------------
// serial_chain_shifter
//
// Loadable bidirectional shift register.  A load captures the whole word and
// the bit order; each shift then moves the next bit onto o_bit.  In MSB-first
// mode the word moves towards the top and o_bit is the top bit; in LSB-first
// mode it moves towards the bottom and o_bit is bit 0.
//
// Ports:
//   i_clk        system clock
//   i_reset_n    asynchronous active-low reset
//   i_load       capture i_data and i_lsb_first this cycle
//   i_lsb_first  bit order captured alongside the data (1 = LSB first)
//   i_data       word to load
//   i_shift      advance to the next bit (ignored while loading)
//   o_bit        bit currently presented to the chain
// ---------------------------------------------------------------------------
module serial_chain_shifter
    import serial_chain_pkg::*;
#(
    parameter int TOTAL = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic             i_lsb_first,
    input  logic [TOTAL-1:0] i_data,
    input  logic             i_shift,
    output logic             o_bit
);

    logic [TOTAL-1:0] shreg_q;
    logic             lsbFirst_q;

    // Load has priority over shift so a new transfer always starts from a
    // freshly captured word.  Vacated positions fill with zero.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shreg_q    <= '0;
            lsbFirst_q <= 1'b0;
        end else if (i_load) begin
            shreg_q    <= i_data;
            lsbFirst_q <= i_lsb_first;
        end else if (i_shift) begin
            if (lsbFirst_q) begin
                shreg_q <= shreg_q >> 1;
            end else begin
                shreg_q <= shreg_q << 1;
            end
        end
    end

    // The presented bit is taken from whichever end the word is moving
    // towards, so no separate output register is needed.
    assign o_bit = lsbFirst_q ? shreg_q[0] : shreg_q[TOTAL-1];

endmodule

// File: rtl/serial_chain_out.sv
// ---------------------------------------------------------------------------
// serial_chain_out
//
// Shifts a WIDTH*CHAINS-bit word into a daisy chain of external
// serial-in/parallel-out latching registers (7-segment digit drivers).
// Every i_clk_stb advances the serial phase: phase 0 raises the serial
// clock over stable data, phase 1 lowers it and moves the next bit out.
// After the last bit a one-strobe storage-latch pulse is issued.
//
// Build option:
//   SERIAL_CHAIN_LATCH_EN  defined     -> LATCH state and o_serial_latch pulse
//                          not defined -> no LATCH state, o_serial_latch tied
//                                         0, the last falling serial clock
//                                         returns straight to IDLE
//
// Ports:
//   i_clk            system clock
//   i_reset_n        asynchronous active-low reset
//   i_clk_stb        one-cycle pulse at twice the serial bit rate
//   i_start_stb      one-cycle transfer request (ignored while busy)
//   i_lsb_first      bit order for the transfer (1 = LSB first)
//   i_parallel_data  word to send; top WIDTH bits reach the farthest register
//                    in MSB-first mode
//   o_busy           high while shifting or latching
//   o_done           one-cycle pulse on return to IDLE
//   o_serial_data    serial data to the chain input
//   o_serial_clk     serial shift clock
//   o_serial_latch   storage-register latch pulse
// ---------------------------------------------------------------------------
module serial_chain_out
    import serial_chain_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CHAINS = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_clk_stb,
    input  logic                      i_start_stb,
    input  logic                      i_lsb_first,
    input  logic [WIDTH*CHAINS-1:0]   i_parallel_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_serial_data,
    output logic                      o_serial_clk,
    output logic                      o_serial_latch
);

    localparam int TOTAL = WIDTH * CHAINS;
    localparam int CNT_W = int'(cntWidth(TOTAL));
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL - 1);

    state_e           state_q;
    logic             phase_q;
    logic [CNT_W-1:0] bitCnt_q;
    logic             serialClk_q;
    logic             busy_q;
    logic             done_q;
    logic             dataEn_q;
`ifdef SERIAL_CHAIN_LATCH_EN
    logic             latch_q;
`endif

    logic loadWord;
    logic shiftWord;
    logic shiftBit;

    // A word is captured only from IDLE; starts during a transfer are
    // dropped.  The register shifts on a falling serial clock, except after
    // the final bit, so the last bit stays on the pin through the latch.
    assign loadWord  = (state_q == ST_IDLE) && i_start_stb;
    assign shiftWord = (state_q == ST_SHIFT) && i_clk_stb && phase_q &&
                       (bitCnt_q != LAST_BIT);

    serial_chain_shifter #(
        .TOTAL (TOTAL)
    ) u_shifter (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_load      (loadWord),
        .i_lsb_first (i_lsb_first),
        .i_data      (i_parallel_data),
        .i_shift     (shiftWord),
        .o_bit       (shiftBit)
    );

    // Transfer controller with registered outputs.  The strobe is only
    // consulted in SHIFT and LATCH, so a strobe coincident with the start
    // request is naturally ignored and the first rising serial clock comes
    // on the following strobe.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            bitCnt_q    <= '0;
            serialClk_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dataEn_q    <= 1'b0;
`ifdef SERIAL_CHAIN_LATCH_EN
            latch_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start_stb) begin
                        state_q     <= ST_SHIFT;
                        phase_q     <= 1'b0;
                        bitCnt_q    <= '0;
                        serialClk_q <= 1'b0;
                        busy_q      <= 1'b1;
                        dataEn_q    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (i_clk_stb) begin
                        if (!phase_q) begin
                            serialClk_q <= 1'b1;
                            phase_q     <= 1'b1;
                        end else begin
                            serialClk_q <= 1'b0;
                            phase_q     <= 1'b0;
                            if (bitCnt_q == LAST_BIT) begin
                                bitCnt_q <= '0;
`ifdef SERIAL_CHAIN_LATCH_EN
                                state_q  <= ST_LATCH;
`else
                                state_q  <= ST_IDLE;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                dataEn_q <= 1'b0;
`endif
                            end else begin
                                bitCnt_q <= bitCnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_LATCH: begin
`ifdef SERIAL_CHAIN_LATCH_EN
                    // Two strobes: raise the latch, then drop it and finish.
                    if (i_clk_stb) begin
                        if (!latch_q) begin
                            latch_q <= 1'b1;
                        end else begin
                            latch_q  <= 1'b0;
                            state_q  <= ST_IDLE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            dataEn_q <= 1'b0;
                        end
                    end
`else
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    dataEn_q <= 1'b0;
`endif
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    dataEn_q <= 1'b0;
                end
            endcase
        end
    end

    // Data is forced low outside a transfer; the enable and the shift
    // register are both flops cleared by reset, so the pin drops at once.
    assign o_serial_data = dataEn_q & shiftBit;
    assign o_serial_clk  = serialClk_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
`ifdef SERIAL_CHAIN_LATCH_EN
    assign o_serial_latch = latch_q;
`else
    assign o_serial_latch = 1'b0;
`endif

endmodule

// File: tb/tb_serial_chain_out.sv
// ---------------------------------------------------------------------------
// tb_serial_chain_out
//
// Bench for serial_chain_out with WIDTH=8, CHAINS=2 and a strobe every four
// clocks.  Stimulus pushes the expected transfer result into a queue; an
// independent monitor collects what the chain pins show and compares when
// o_done pulses.  Expectations follow SERIAL_CHAIN_LATCH_EN when defined.
// ---------------------------------------------------------------------------
module tb_serial_chain_out;

    localparam int WIDTH  = 8;
    localparam int CHAINS = 2;
    localparam int TOTAL  = WIDTH * CHAINS;
`ifdef SERIAL_CHAIN_LATCH_EN
    localparam int LATCH_ON = 1;
`else
    localparam int LATCH_ON = 0;
`endif
    localparam int EXP_BUSY  = 2 * TOTAL + 2 * LATCH_ON;
    localparam int EXP_LATCH = LATCH_ON;

    logic             i_clk;
    logic             i_reset_n;
    logic             i_clk_stb;
    logic             i_start_stb;
    logic             i_lsb_first;
    logic [TOTAL-1:0] i_parallel_data;
    logic             o_busy;
    logic             o_done;
    logic             o_serial_data;
    logic             o_serial_clk;
    logic             o_serial_latch;

    typedef struct {
        logic [TOTAL-1:0] bits;
        int               edges;
        int               busyStb;
        int               latchPulses;
        int               latchWidth;
    } exp_t;

    exp_t expQ[$];

    int total = 0;
    int bad   = 0;
    int stbPhase = 0;

    // Monitor accumulators for the transfer in flight.
    logic [TOTAL-1:0] monBits;
    int               monEdges;
    int               monBusyStb;
    int               monLatchP;
    int               monLatchW;
    logic             prevClk;
    logic             prevLatch;

    serial_chain_out #(
        .WIDTH  (WIDTH),
        .CHAINS (CHAINS)
    ) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_clk_stb       (i_clk_stb),
        .i_start_stb     (i_start_stb),
        .i_lsb_first     (i_lsb_first),
        .i_parallel_data (i_parallel_data),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_serial_data   (o_serial_data),
        .o_serial_clk    (o_serial_clk),
        .o_serial_latch  (o_serial_latch)
    );

    // 10 ns system clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Strobe high for one cycle out of every four, updated just after each
    // rising edge.
    initial begin
        i_clk_stb = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            stbPhase  = (stbPhase + 1) % 4;
            i_clk_stb = (stbPhase == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [TOTAL-1:0] bitRev(input logic [TOTAL-1:0] v);
        logic [TOTAL-1:0] r;
        for (int i = 0; i < TOTAL; i++) begin
            r[i] = v[TOTAL-1-i];
        end
        return r;
    endfunction

    // Watch the pins on the falling clock edge and compare on each o_done.
    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            monBits    = '0;
            monEdges   = 0;
            monBusyStb = 0;
            monLatchP  = 0;
            monLatchW  = 0;
            prevClk    = 1'b0;
            prevLatch  = 1'b0;
        end else begin
            if (i_clk_stb && o_busy) monBusyStb++;
            if (i_clk_stb && o_serial_latch) monLatchW++;
            if (o_serial_latch && !prevLatch) monLatchP++;
            if (o_serial_clk && !prevClk) begin
                monBits = {monBits[TOTAL-2:0], o_serial_data};
                monEdges++;
            end
            if (o_done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", o_done, 1'b0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("bits", monBits, e.bits);
                    checkOutput("edges", monEdges, e.edges);
                    checkOutput("busyStrobes", monBusyStb, e.busyStb);
                    checkOutput("latchPulses", monLatchP, e.latchPulses);
                    checkOutput("latchWidth", monLatchW, e.latchWidth);
                end
                monBits    = '0;
                monEdges   = 0;
                monBusyStb = 0;
                monLatchP  = 0;
                monLatchW  = 0;
            end
            prevClk   = o_serial_clk;
            prevLatch = o_serial_latch;
        end
    end

    // Start one transfer, optionally aligned to a strobe and optionally with
    // an extra start request while busy.  When expectDone is set the
    // expected result is queued and the task waits for completion.
    task automatic applyStimulus(input logic [TOTAL-1:0] data, input logic lsb,
                                 input logic coincident, input logic midStart,
                                 input logic expectDone);
        exp_t e;
        logic firstBit;
        if (expectDone) begin
            e.bits        = lsb ? bitRev(data) : data;
            e.edges       = TOTAL;
            e.busyStb     = EXP_BUSY;
            e.latchPulses = EXP_LATCH;
            e.latchWidth  = EXP_LATCH;
            expQ.push_back(e);
        end
        do begin
            @(posedge i_clk);
            #2;
        end while (i_clk_stb !== coincident);
        i_start_stb     = 1'b1;
        i_parallel_data = data;
        i_lsb_first     = lsb;
        @(posedge i_clk);
        #2;
        i_start_stb = 1'b0;
        firstBit = lsb ? data[0] : data[TOTAL-1];
        checkOutput("startBusy", o_busy, 1'b1);
        checkOutput("startClk", o_serial_clk, 1'b0);
        checkOutput("firstBit", o_serial_data, firstBit);
        if (midStart) begin
            repeat (40) @(posedge i_clk);
            #2;
            i_start_stb     = 1'b1;
            i_parallel_data = '1;
            i_lsb_first     = ~lsb;
            @(posedge i_clk);
            #2;
            i_start_stb = 1'b0;
        end
        if (expectDone) begin
            for (int c = 0; c < 400; c++) begin
                @(negedge i_clk);
                if (o_done) break;
            end
            checkOutput("doneSeen", o_done, 1'b1);
            repeat (12) @(posedge i_clk);
            #2;
            checkOutput("idleBusy", o_busy, 1'b0);
            checkOutput("idleData", o_serial_data, 1'b0);
        end
    endtask

    initial begin
        int   seen;
        logic prev;
        i_reset_n       = 1'b0;
        i_start_stb     = 1'b0;
        i_lsb_first     = 1'b0;
        i_parallel_data = '0;

        #23;
        checkOutput("rstBusy", o_busy, 1'b0);
        checkOutput("rstDone", o_done, 1'b0);
        checkOutput("rstData", o_serial_data, 1'b0);
        checkOutput("rstClk", o_serial_clk, 1'b0);
        checkOutput("rstLatch", o_serial_latch, 1'b0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (3) @(negedge i_clk);

        $display("[TB] MSB first A53C");
        applyStimulus(16'hA53C, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("[TB] LSB first A53C");
        applyStimulus(16'hA53C, 1'b1, 1'b0, 1'b0, 1'b1);
        $display("[TB] start while busy is ignored");
        applyStimulus(16'hA53C, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("[TB] asynchronous reset mid-transfer");
        applyStimulus(16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0);
        seen = 0;
        prev = 1'b0;
        for (int c = 0; c < 200 && seen < 5; c++) begin
            @(negedge i_clk);
            if (o_serial_clk && !prev) seen++;
            prev = o_serial_clk;
        end
        checkOutput("abortEdges", seen, 5);
        #2;
        i_reset_n = 1'b0;
        #1;
        checkOutput("abortClk", o_serial_clk, 1'b0);
        checkOutput("abortData", o_serial_data, 1'b0);
        checkOutput("abortLatch", o_serial_latch, 1'b0);
        checkOutput("abortBusy", o_busy, 1'b0);
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (20) @(negedge i_clk);
        checkOutput("abortNoLatch", o_serial_latch, 1'b0);
        checkOutput("abortIdle", o_busy, 1'b0);
        applyStimulus(16'hC3A5, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] start coincident with strobe");
        applyStimulus(16'h3C96, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("[TB] single set bit, MSB first");
        applyStimulus(16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (8) @(negedge i_clk);
        checkOutput("queueEmpty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
